// File: rtl/systolic_psum_drain.sv
// systolic_psum_drain: deskews the south-edge partial sums of the MAC array,
// requantizes each lane to unsigned 8-bit (rounding right-shift, clamp) and
// buffers finished rows in a first-word-fall-through FIFO behind valid/ready.
// Optional build macro SAT_STATS_EN enables the saturated-lane counter on
// sat_count; without it sat_count is tied to zero.
module systolic_psum_drain #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [COLS*32-1:0]           in_psum,
    input  logic [4:0]                   shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS*8-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         drop_err,
    output logic [15:0]                  sat_count
);

    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ROW_W  = COLS * 8;

    // Rounding arithmetic right-shift on a 33-bit signed intermediate.
    function automatic logic signed [32:0] rescale(input logic [31:0] p, input logic [4:0] sh);
        logic signed [32:0] ext;
        logic signed [32:0] bias;
        ext = signed'({p[31], p});
        if (sh == 5'd0) begin
            rescale = ext;
        end else begin
            bias    = signed'(33'(1) << (sh - 5'd1));
            rescale = (ext + bias) >>> sh;
        end
    endfunction

    // Clamp a rescaled value into the unsigned 8-bit activation range.
    function automatic logic [7:0] quant_byte(input logic signed [32:0] r);
        if (r < 33'sd0) begin
            quant_byte = 8'd0;
        end else if (r > 33'sd255) begin
            quant_byte = 8'hFF;
        end else begin
            quant_byte = r[7:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Valid pipeline: final tap marks the cycle in which a row is aligned.
    // ------------------------------------------------------------------
    logic [COLS-2:0] vpipe;

    // Delay in_valid by COLS-1 cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= in_valid;
            for (int unsigned i = 1; i < COLS - 1; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Deskew: lane c is delayed COLS-1-c cycles so all lanes line up.
    // ------------------------------------------------------------------
    logic [COLS*32-1:0] aligned;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        if (c == COLS - 1) begin : g_direct
            assign aligned[c*32 +: 32] = in_psum[c*32 +: 32];
        end else begin : g_delay
            localparam int unsigned N = COLS - 1 - c;
            logic [31:0] chain [N];

            // Shift the lane through its delay registers.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        chain[i] <= '0;
                    end
                end else begin
                    chain[0] <= in_psum[c*32 +: 32];
                    for (int unsigned i = 1; i < N; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign aligned[c*32 +: 32] = chain[N-1];
        end
    end

    // ------------------------------------------------------------------
    // Requantize and capture into the quant register.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] q_data_next;
    logic [ROW_W-1:0] q_data;
    logic             q_valid;

    // Per-lane rescale and clamp using the current shift.
    always_comb begin
        q_data_next = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            q_data_next[c*8 +: 8] = quant_byte(rescale(aligned[c*32 +: 32], shift));
        end
    end

    // Quant register: one aligned, requantized row per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            q_valid <= vpipe[COLS-2];
            q_data  <= q_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO with a registered head row.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level_next;
    logic [ROW_W-1:0] head_next;
    logic             pop;
    logic             push;
    logic             full;

    // Push/pop decisions and the head row visible after this cycle.
    always_comb begin
        pop        = out_valid && out_ready;
        full       = (level == LVL_W'(DEPTH));
        push       = q_valid && (!full || pop);
        level_next = level + LVL_W'(push) - LVL_W'(pop);
        rd_next    = rd_ptr + PTR_W'(pop);
        head_next  = out_data;
        if (level_next != '0) begin
            // Nothing older survives the pop: the incoming row becomes head.
            if (level == LVL_W'(pop)) begin
                head_next = q_data;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Row storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_data;
        end
    end

    // Pointers, occupancy, head register and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            drop_err  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_next;
            level     <= level_next;
            out_valid <= (level_next != '0);
            out_data  <= head_next;
            if (q_valid && full && !pop) begin
                drop_err <= 1'b1;
            end
        end
    end

`ifdef SAT_STATS_EN
    // ------------------------------------------------------------------
    // Saturated-lane statistics for rows that enter the FIFO.
    // ------------------------------------------------------------------
    localparam int unsigned NSAT_W = $clog2(COLS + 1);

    function automatic logic lane_clamps(input logic signed [32:0] r);
        lane_clamps = (r < 33'sd0) || (r > 33'sd255);
    endfunction

    logic [NSAT_W-1:0] nsat_next;
    logic [NSAT_W-1:0] q_nsat;
    logic [16:0]       sat_sum;

    // Count clamped lanes of the row being quantized.
    always_comb begin
        nsat_next = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (lane_clamps(rescale(aligned[c*32 +: 32], shift))) begin
                nsat_next = nsat_next + NSAT_W'(1);
            end
        end
    end

    // Clamp count travels alongside the quant register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_nsat <= '0;
        end else begin
            q_nsat <= nsat_next;
        end
    end

    // Widened sum for the saturating accumulate.
    always_comb begin
        sat_sum = 17'(sat_count) + 17'(q_nsat);
    end

    // Accumulate on accepted pushes, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_count <= '0;
        end else if (push) begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Self-checking bench for systolic_psum_drain (COLS=4, DEPTH=4). Rows are
// injected with one cycle of skew per lane; expected rows are queued at
// injection and compared as the DUT hands them out.
module tb_systolic_psum_drain;

    localparam int unsigned COLS  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = COLS * 32;
    localparam int unsigned OW    = COLS * 8;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [RW-1:0] in_psum;
    logic [4:0]    shift;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [2:0]    level;
    logic          drop_err;
    logic [15:0]   sat_count;

    systolic_psum_drain #(.COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop_err  (drop_err),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [OW-1:0] exp_q[$];
    logic [RW-1:0] hist_data [COLS];
    bit            hist_v    [COLS];
    int            exp_sat   = 0;

    function automatic logic [RW-1:0] mk(input int a, input int b, input int c, input int d);
        mk = {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Reference requantizer in 64-bit arithmetic: {saturated, byte}.
    function automatic logic [8:0] model_lane(input logic [31:0] p, input logic [4:0] sh);
        longint v;
        longint r;
        v = longint'(signed'(p));
        if (sh == 5'd0) r = v;
        else            r = (v + (64'sd1 <<< (sh - 5'd1))) >>> sh;
        if (r < 0)        model_lane = {1'b1, 8'd0};
        else if (r > 255) model_lane = {1'b1, 8'd255};
        else              model_lane = {1'b0, 8'(r)};
    endfunction

    function automatic logic [OW-1:0] model_row(input logic [RW-1:0] row, input logic [4:0] sh,
                                                output int nsat);
        logic [8:0] l;
        nsat = 0;
        model_row = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            l = model_lane(row[c*32 +: 32], sh);
            model_row[c*8 +: 8] = l[7:0];
            nsat += int'(l[8]);
        end
    endfunction

    function automatic logic [15:0] sat_expect();
`ifdef SAT_STATS_EN
        sat_expect = 16'(exp_sat);
`else
        sat_expect = 16'h0000;
`endif
    endfunction

    // One cycle of stimulus: start a row (optional) and drive skewed lanes.
    task automatic step(input bit v, input logic [RW-1:0] row, input bit keep);
        int            ns;
        logic [OW-1:0] e;
        for (int j = int'(COLS) - 1; j > 0; j--) begin
            hist_data[j] = hist_data[j-1];
            hist_v[j]    = hist_v[j-1];
        end
        hist_data[0] = row;
        hist_v[0]    = v;
        if (v && keep) begin
            e = model_row(row, shift, ns);
            exp_q.push_back(e);
            exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
        end
        in_valid = v;
        for (int c = 0; c < int'(COLS); c++) begin
            in_psum[c*32 +: 32] = hist_v[c] ? hist_data[c][c*32 +: 32] : 32'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int j = 0; j < int'(COLS); j++) hist_v[j] = 1'b0;
        exp_q.delete();
        exp_sat = 0;
    endtask

    // Output monitor: every accepted head row must match the scoreboard.
    always @(negedge clk) begin : mon
        logic [OW-1:0] e;
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_row: unexpected row %h, nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL out_row: got %h expected %h", out_data, e);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        shift     = 5'd4;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_psum  = {4{32'($urandom)}};
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({out_valid, out_data, level, drop_err, sat_count} !== '0)
            $display("FAIL reset_values: got v=%b d=%h l=%0d e=%b s=%0d expected all zero",
                     out_valid, out_data, level, drop_err, sat_count);
        else n_pass++;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        for (int j = 0; j < int'(COLS); j++) hist_v[j] = 1'b0;
        exp_q.delete();
        idle(8);
        n_checks++;
        if (out_valid !== 1'b0 || level !== 3'd0)
            $display("FAIL reset_ignores_in_valid: got v=%b l=%0d expected 0 0", out_valid, level);
        else n_pass++;
    endtask

    // Latency check: out_valid only in cycle 5 for a row started in cycle 0.
    task automatic latency_probe();
        for (int k = 1; k <= 6; k++) begin
            n_checks++;
            if (out_valid !== (k == 5))
                $display("FAIL latency_c%0d: got out_valid %b expected %b", k, out_valid, (k == 5));
            else n_pass++;
            idle(1);
        end
    endtask

    task automatic test_single_row();
        shift     = 5'd4;
        out_ready = 1'b1;
        step(1'b1, mk(256, 24, 7, 0), 1'b1);
        latency_probe();
        n_checks++;
        if (out_data !== {8'd0, 8'd0, 8'd2, 8'd16} || level !== 3'd0)
            $display("FAIL single_hold: got d=%h l=%0d expected 00000210 0", out_data, level);
        else n_pass++;
        n_checks++;
        if (sat_count !== 16'd0) $display("FAIL single_sat: got %0d expected 0", sat_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        shift = 5'd4;
        step(1'b1, mk(-5, 5000, 4087, 4088), 1'b1);
        idle(8);
        n_checks++;
        if (out_data !== {8'd255, 8'd255, 8'd255, 8'd0})
            $display("FAIL sat_row: got %h expected ffffff00", out_data);
        else n_pass++;
        n_checks++;
        if (sat_count !== sat_expect())
            $display("FAIL sat_count: got %0d expected %0d", sat_count, sat_expect());
        else n_pass++;
    endtask

    task automatic test_shift_edges();
        shift = 5'd0;
        step(1'b1, mk(200, 300, -1, 255), 1'b1);
        idle(8);
        n_checks++;
        if (out_data !== {8'd255, 8'd0, 8'd255, 8'd200})
            $display("FAIL shift0_row: got %h expected ff00ffc8", out_data);
        else n_pass++;
        shift = 5'd31;
        step(1'b1, mk(32'h7FFFFFFF, 32'h40000000, 32'h80000000, 32'hFFFFFFFF), 1'b1);
        idle(8);
        n_checks++;
        if (out_data !== {8'd0, 8'd0, 8'd1, 8'd1})
            $display("FAIL shift31_row: got %h expected 00000101", out_data);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL shift_drain: got %0d rows left expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        shift     = 5'd6;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, mk(int'($urandom_range(0, 40000)) - 5000, int'($urandom_range(0, 20000)),
                          int'($urandom_range(0, 70000)) - 30000, int'($urandom)), 1'b1);
        end
        idle(6);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL b2b_throughput: got %0d rows pending expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (sat_count !== sat_expect())
            $display("FAIL b2b_sat: got %0d expected %0d", sat_count, sat_expect());
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        shift     = 5'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, mk(4*i, 4*i + 100, 4*i + 200, 4*i + 300), 1'b1);
        idle(1);
        step(1'b1, mk(40, 80, 120, 160), 1'b1);
        idle(2);
        n_checks++;
        if (level !== 3'd4 || out_valid !== 1'b1)
            $display("FAIL pp_full: got l=%0d v=%b expected 4 1", level, out_valid);
        else n_pass++;
        idle(1);
        out_ready = 1'b1;
        idle(1);
        n_checks++;
        if (level !== 3'd4 || drop_err !== 1'b0)
            $display("FAIL pp_simul: got l=%0d drop=%b expected 4 0", level, drop_err);
        else n_pass++;
        idle(6);
        n_checks++;
        if (exp_q.size() != 0 || level !== 3'd0)
            $display("FAIL pp_drain: got %0d pending l=%0d expected 0 0", exp_q.size(), level);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        shift     = 5'd3;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, mk(8*i, 8*i + 16, 8*i + 32, 8*i + 48), (i < 4));
        idle(6);
        n_checks++;
        if (level !== 3'd4 || drop_err !== 1'b1)
            $display("FAIL bp_full: got l=%0d drop=%b expected 4 1", level, drop_err);
        else n_pass++;
        out_ready = 1'b1;
        idle(6);
        n_checks++;
        if (exp_q.size() != 0 || level !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL bp_drain: got %0d pending l=%0d v=%b expected 0 0 0",
                     exp_q.size(), level, out_valid);
        else n_pass++;
        n_checks++;
        if (drop_err !== 1'b1) $display("FAIL bp_sticky: got %b expected 1", drop_err);
        else n_pass++;
        n_checks++;
        if (sat_count !== sat_expect())
            $display("FAIL bp_sat: got %0d expected %0d", sat_count, sat_expect());
        else n_pass++;
    endtask

    task automatic test_reset_mid_row();
        shift     = 5'd4;
        out_ready = 1'b0;
        step(1'b1, mk(1000, 2000, 3000, 4000), 1'b0);
        idle(4);
        n_checks++;
        if (level !== 3'd1) $display("FAIL mid_pre_level: got %0d expected 1", level);
        else n_pass++;
        step(1'b1, mk(160, 320, 480, 640), 1'b0);
        idle(1);
        reset_n = 1'b0;
        idle(1);
        n_checks++;
        if ({out_valid, out_data, level, drop_err, sat_count} !== '0)
            $display("FAIL mid_reset_values: got v=%b d=%h l=%0d e=%b s=%0d expected all zero",
                     out_valid, out_data, level, drop_err, sat_count);
        else n_pass++;
        reset_n = 1'b1;
        for (int j = 0; j < int'(COLS); j++) hist_v[j] = 1'b0;
        exp_q.delete();
        exp_sat   = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL mid_no_output_c%0d: got 1 expected 0", k);
            else n_pass++;
        end
        step(1'b1, mk(512, 48, -300, 9999), 1'b1);
        latency_probe();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL mid_fresh_row: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_psum   = '0;
        shift     = 5'd0;
        out_ready = 1'b0;
        for (int j = 0; j < int'(COLS); j++) begin
            hist_v[j]    = 1'b0;
            hist_data[j] = '0;
        end
        #1;
        test_reset();
        test_single_row();
        test_saturation();
        test_shift_edges();
        test_back_to_back();
        test_full_push_pop();
        test_backpressure();
        do_reset();
        test_reset_mid_row();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
